// File: rtl/result_fifo.sv
// result_fifo: buffers convolution results from the datapath and drains
// them to an external reader over a valid/ready handshake on command.
module result_fifo #(
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            fifo_command,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  drain_busy,
  output logic                  drain_done
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  localparam logic [1:0]            CMD_READ   = 2'b01;
  localparam logic [1:0]            CMD_WRITE  = 2'b10;
  localparam logic [1:0]            CMD_FLUSH  = 2'b11;
  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  overflow_reg;
  state_t                state_reg;
  logic [DATA_WIDTH-1:0] dout_reg;
  logic                  dout_valid_reg;
  logic                  drain_busy_reg;
  logic                  drain_done_reg;

  logic flush;
  logic wr_req;
  logic wr_en;
  logic pop;

  assign flush  = (fifo_command == CMD_FLUSH);
  assign wr_req = (fifo_command == CMD_WRITE);
  // A write while full is dropped even if a pop frees a slot this cycle.
  assign wr_en  = wr_req && (count_reg != COUNT_FULL);
  assign pop    = (state_reg == PRESENT) && dout_valid_reg && dout_ready;

  assign count      = count_reg;
  assign full       = (count_reg == COUNT_FULL);
  assign empty      = (count_reg == '0);
  assign overflow   = overflow_reg;
  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign drain_busy = drain_busy_reg;
  assign drain_done = drain_done_reg;

  // Occupancy after this cycle's write and pop; also decides end of drain.
  always_comb begin
    count_next = count_reg;
    if (wr_en && !pop)
      count_next = count_reg + COUNT_ONE;
    else if (!wr_en && pop)
      count_next = count_reg - COUNT_ONE;
  end

  // Storage write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= data_in;
  end

  // Registered read port; loaded only in FETCH so dout holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dout_reg <= '0;
    else if ((state_reg == FETCH) && !flush)
      dout_reg <= mem[rd_ptr_reg];
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      if (wr_req && full)
        overflow_reg <= 1'b1;
    end
  end

  // Drain state machine with registered handshake and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      dout_valid_reg <= 1'b0;
      drain_busy_reg <= 1'b0;
      drain_done_reg <= 1'b0;
    end else if (flush) begin
      state_reg      <= IDLE;
      dout_valid_reg <= 1'b0;
      drain_busy_reg <= 1'b0;
      drain_done_reg <= 1'b0;
    end else begin
      drain_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (fifo_command == CMD_READ) begin
            drain_busy_reg <= 1'b1;
            if (count_reg != '0) begin
              state_reg <= FETCH;
            end else begin
              state_reg      <= DONE;
              drain_done_reg <= 1'b1;
            end
          end
        end
        FETCH: begin
          state_reg      <= PRESENT;
          dout_valid_reg <= 1'b1;
        end
        PRESENT: begin
          if (pop) begin
            dout_valid_reg <= 1'b0;
            if (count_next == '0) begin
              state_reg      <= DONE;
              drain_done_reg <= 1'b1;
            end else begin
              state_reg <= FETCH;
            end
          end
        end
        DONE: begin
          state_reg      <= IDLE;
          drain_busy_reg <= 1'b0;
        end
        default: begin
          state_reg      <= IDLE;
          dout_valid_reg <= 1'b0;
          drain_busy_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_fifo.sv
// tb_result_fifo: directed checks of the result FIFO write, drain, stall,
// overflow, wrap-around, flush and asynchronous reset behaviour.
module tb_result_fifo;

  logic        clk;
  logic        reset;
  logic [1:0]  fifo_command;
  logic [17:0] data_in;
  logic [17:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [8:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        drain_busy;
  logic        drain_done;

  int n_vec;
  int n_miss;

  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];
  int          hs_cyc[$];
  int          done_pulses;
  int          done_cyc;
  int          valid_seen;

  result_fifo #(.DATA_WIDTH(18), .DEPTH(256), .ADDR_WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .fifo_command(fifo_command),
    .data_in(data_in),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .count(count),
    .full(full),
    .empty(empty),
    .overflow(overflow),
    .drain_busy(drain_busy),
    .drain_done(drain_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; writes one word on the following posedge.
  task automatic wr(input logic [17:0] d);
    fifo_command = 2'b10;
    data_in      = d;
    @(negedge clk);
    fifo_command = 2'b00;
  endtask

  task automatic flush_cmd();
    fifo_command = 2'b11;
    @(negedge clk);
    fifo_command = 2'b00;
  endtask

  // Issues a read command and collects words; optionally stalls on one word.
  task automatic drain(input int stall_idx, input int stall_len, input int budget);
    int          cyc;
    int          stalled;
    bit          finished;
    logic [17:0] held;
    got_q.delete();
    hs_cyc.delete();
    done_pulses = 0;
    done_cyc    = -1;
    valid_seen  = 0;
    stalled     = 0;
    finished    = 0;
    held        = '0;
    dout_ready   = 1'b1;
    fifo_command = 2'b01;
    @(negedge clk);
    fifo_command = 2'b00;
    cyc = 1;
    while (!finished && cyc < budget) begin
      if (drain_done) begin
        done_pulses++;
        done_cyc = cyc;
        finished = 1;
      end
      if (dout_valid) begin
        valid_seen++;
        if (got_q.size() == stall_idx && stalled < stall_len) begin
          dout_ready = 1'b0;
          if (stalled == 0)
            held = dout;
          else
            check("stall_dout_stable", dout, held);
          stalled++;
        end else begin
          dout_ready = 1'b1;
          got_q.push_back(dout);
          hs_cyc.push_back(cyc);
        end
      end else if (got_q.size() == stall_idx && stalled > 0 && stalled < stall_len) begin
        check("stall_valid_held", dout_valid, 1'b1);
        stalled = stall_len;
      end
      @(negedge clk);
      cyc++;
    end
    dout_ready = 1'b1;
    if (!finished)
      check("drain_timeout", 32'd0, 32'd1);
    check("drain_done_one_cycle", drain_done, 1'b0);
    check("drain_done_pulses", done_pulses, 1);
  endtask

  // Compares collected words against exp_q.
  task automatic compare_words(input string tag);
    check({tag, "_size"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i])
        check({tag, "_word"}, got_q[i], exp_q[i]);
      else
        n_vec++;
  endtask

  initial begin
    n_vec        = 0;
    n_miss       = 0;
    reset        = 1'b1;
    fifo_command = 2'b00;
    data_in      = '0;
    dout_ready   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_drain_busy", drain_busy, 0);
    check("rst_drain_done", drain_done, 0);
    reset = 1'b0;
    @(negedge clk);
    $display("reset checked");

    // Five words, free-running drain.
    exp_q.delete();
    for (int i = 1; i <= 5; i++) begin
      wr(18'(i));
      exp_q.push_back(18'(i));
    end
    check("t1_count5", count, 5);
    check("t1_not_empty", empty, 0);
    drain(-1, 0, 100);
    compare_words("t1");
    check("t1_first_hs", hs_cyc.size() > 0 ? hs_cyc[0] : -1, 2);
    for (int i = 1; i < hs_cyc.size(); i++)
      check("t1_hs_spacing", hs_cyc[i] - hs_cyc[i-1], 2);
    check("t1_done_after_last", done_cyc, hs_cyc.size() > 0 ? hs_cyc[hs_cyc.size()-1] + 1 : -99);
    check("t1_valid_cycles", valid_seen, 5);
    check("t1_count0", count, 0);
    check("t1_empty", empty, 1);
    check("t1_busy_idle", drain_busy, 0);
    $display("five-word drain: %0d words", got_q.size());

    // Fill to 256, then one dropped write.
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      wr(18'(32'h100 + i));
      exp_q.push_back(18'(32'h100 + i));
    end
    check("t2_full", full, 1);
    check("t2_count256", count, 256);
    check("t2_no_overflow_yet", overflow, 0);
    wr(18'h3FFFF);
    check("t2_overflow", overflow, 1);
    check("t2_count_still256", count, 256);
    drain(-1, 0, 1000);
    compare_words("t2");
    check("t2_count0", count, 0);
    check("t2_overflow_sticky", overflow, 1);
    flush_cmd();
    check("t2_flush_clears_ovf", overflow, 0);
    $display("full/overflow drain: %0d words", got_q.size());

    // Stall on the second word for four cycles.
    exp_q.delete();
    wr(18'h00010); exp_q.push_back(18'h00010);
    wr(18'h00020); exp_q.push_back(18'h00020);
    wr(18'h00030); exp_q.push_back(18'h00030);
    drain(1, 4, 100);
    compare_words("t3");
    check("t3_count0", count, 0);
    $display("stalled drain: %0d words", got_q.size());

    // Read command with nothing stored.
    exp_q.delete();
    drain(-1, 0, 20);
    check("t4_done_cycle", done_cyc, 1);
    check("t4_no_valid", valid_seen, 0);
    check("t4_no_words", got_q.size(), 0);
    check("t4_busy_idle", drain_busy, 0);
    $display("empty drain: done at cycle %0d", done_cyc);

    // Pointer wrap-around.
    exp_q.delete();
    for (int i = 0; i < 250; i++) begin
      wr(18'(32'h200 + i));
      exp_q.push_back(18'(32'h200 + i));
    end
    drain(-1, 0, 1000);
    compare_words("t5a");
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      wr(18'(32'h3000 + i));
      exp_q.push_back(18'(32'h3000 + i));
    end
    check("t5_count10", count, 10);
    drain(-1, 0, 100);
    compare_words("t5b");
    check("t5_count0", count, 0);
    $display("wrap drain: %0d words", got_q.size());

    // Asynchronous reset while a word is presented.
    begin
      int  wait_n;
      int  done_seen;
      wr(18'h00A1);
      wr(18'h00A2);
      wr(18'h00A3);
      dout_ready   = 1'b0;
      fifo_command = 2'b01;
      @(negedge clk);
      fifo_command = 2'b00;
      wait_n = 0;
      while (!dout_valid && wait_n < 10) begin
        @(negedge clk);
        wait_n++;
      end
      check("t6_reached_present", dout_valid, 1);
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_valid_drop", dout_valid, 0);
      check("t6_rst_count", count, 0);
      check("t6_rst_empty", empty, 1);
      check("t6_rst_overflow", overflow, 0);
      #1;
      reset = 1'b0;
      dout_ready = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (drain_done) done_seen++;
      end
      check("t6_rst_no_done", done_seen, 0);
      check("t6_rst_busy", drain_busy, 0);
      $display("async reset mid-drain applied");
    end

    // Flush while a word is presented, with overflow set beforehand.
    begin
      int wait_n;
      int done_seen;
      for (int i = 0; i < 257; i++)
        wr(18'(32'h500 + i));
      check("t7_overflow_set", overflow, 1);
      dout_ready   = 1'b0;
      fifo_command = 2'b01;
      @(negedge clk);
      fifo_command = 2'b00;
      wait_n = 0;
      while (!dout_valid && wait_n < 10) begin
        @(negedge clk);
        wait_n++;
      end
      check("t7_reached_present", dout_valid, 1);
      flush_cmd();
      check("t7_flush_valid_drop", dout_valid, 0);
      check("t7_flush_count", count, 0);
      check("t7_flush_empty", empty, 1);
      check("t7_flush_overflow", overflow, 0);
      check("t7_flush_busy", drain_busy, 0);
      dout_ready = 1'b1;
      done_seen = drain_done ? 1 : 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (drain_done) done_seen++;
      end
      check("t7_flush_no_done", done_seen, 0);
      $display("flush mid-drain applied");
    end

    // FIFO still usable after the flush.
    exp_q.delete();
    wr(18'h2BEEF); exp_q.push_back(18'h2BEEF);
    drain(-1, 0, 50);
    compare_words("t8");
    $display("post-flush drain: %0d words", got_q.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
